wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding enabled; 0 = reads return stored value only.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port WB_Final_Wr  input  4  write-enable vector from writeback, already gated by DisWr: [3]=RFWr, [2]=CP0Wr, [1]=HIWr, [0]=LOWr.
REQ-005 SHALL have port WB_Dst  input  5  GPR destination index.
REQ-006 SHALL have port WB_Result  input  32  GPR write data; also LO write data.
REQ-007 SHALL have port WB_HiData  input  32  HI write data.
REQ-008 SHALL have port WB_PC  input  32  PC of the writeback instruction.
REQ-009 SHALL have ports ID_rs, ID_rt  input  5 each  read addresses.
REQ-010 SHALL have ports RF_RsData, RF_RtData  output  32 each  read data.
REQ-011 SHALL have ports RF_Hi, RF_Lo  output  32 each  HI/LO contents.
REQ-012 SHALL have port CP0_WrReq  output  1  registered CP0 write request.
REQ-013 SHALL have ports debug_wb_pc  output  32, debug_wb_rf_wen  output  4, debug_wb_rf_wnum  output  5, debug_wb_rf_wdata  output  32  registered commit trace.
REQ-014 SHALL have port Retired  output  32  count of committed writes.

Function
REQ-015 SHALL hold 31 GPRs (1..31); GPR0 SHALL read 0 always; writes to index 0 SHALL be discarded.
REQ-016 SHALL write WB_Result into GPR[WB_Dst] on the rising edge when RFWr=1 and WB_Dst!=0.
REQ-017 SHALL write WB_HiData into HI when HIWr=1, and WB_Result into LO when LOWr=1; both SHALL update in the same edge when both are set.
REQ-018 Reads SHALL be combinational from ID_rs/ID_rt.
REQ-019 With BYPASS=1, a read with addr==WB_Dst, RFWr=1 and addr!=0 SHALL return WB_Result in the same cycle; RF_Hi/RF_Lo SHALL likewise forward WB_HiData/WB_Result when HIWr/LOWr=1.
REQ-020 With BYPASS=0, reads SHALL return pre-edge stored values; new data SHALL be visible the cycle after the write.
REQ-021 Both read ports SHALL forward independently; rs==rt SHALL give identical data.
REQ-022 CP0_WrReq SHALL equal the previous cycle's CP0Wr; the CP0 register SHALL NOT be written here.
REQ-023 Trace registers SHALL capture on every edge: debug_wb_pc<=WB_PC; debug_wb_rf_wen<={4{RFWr && WB_Dst!=0}}; debug_wb_rf_wnum<=WB_Dst; debug_wb_rf_wdata<=WB_Result. Trace latency SHALL be 1 cycle.
REQ-024 Retired SHALL increment by 1 on each edge where any bit of WB_Final_Wr is 1; it SHALL wrap 0xFFFFFFFF -> 0 with no flag.
REQ-025 WB_Final_Wr=0 SHALL cause no state change except trace capture; debug_wb_rf_wen SHALL be 0.

Reset
REQ-026 On a rising edge with rst=1: all GPRs, HI and LO SHALL be 0, CP0_WrReq 0, Retired 0, and all trace outputs 0.
REQ-027 rst SHALL override a simultaneous write: no write SHALL take effect in the reset cycle.
REQ-028 With BYPASS=1, forwarding SHALL stay combinational during rst=1; stored values SHALL read 0 from the cycle after the reset edge.

Verification
REQ-029 Write: RFWr=1, Dst=5, Result=0xDEADBEEF; next cycle rs=5 -> RF_RsData=0xDEADBEEF; debug_wb_rf_wen=0xF, debug_wb_rf_wnum=5.
REQ-030 GPR0: RFWr=1, Dst=0, Result=0x12345678 -> rs=0 reads 0 in the same cycle and the next; debug_wb_rf_wen=0; Retired +1.
REQ-031 Bypass: BYPASS=1, rs=rt=7, RFWr=1, Dst=7, Result=0xA5A5A5A5 -> both reads 0xA5A5A5A5 in the same cycle. With BYPASS=0 the same stimulus -> both reads return the old value in that cycle and 0xA5A5A5A5 in the next.
REQ-032 HI/LO: HIWr=LOWr=1, HiData=0x1, Result=0x2 -> next cycle RF_Hi=1 and RF_Lo=2; Retired +1 (not +2).
REQ-033 Wrap and reset: Retired forced to 0xFFFFFFFF, then one write -> Retired=0; then rst=1 together with RFWr=1, Dst=3 -> GPR3=0 and all outputs 0 after the edge.

Source files
------------

// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile_if
//  Purpose  : Bundles the writeback-side write signals, the decode-side read
//             addresses and every register-file output into one interface.
//  Ports    : WB_Final_Wr / WB_Dst / WB_Result / WB_HiData / WB_PC  (write side)
//             ID_rs / ID_rt                                         (read addresses)
//             RF_RsData / RF_RtData / RF_Hi / RF_Lo                 (read data)
//             CP0_WrReq, debug_wb_* trace, Retired                  (status)
//  Modports : slave  - the register file itself
//             master - whoever drives writeback/decode and consumes results
//  Revision : 1.0  initial release
// ============================================================================
interface wb_regfile_if;
  logic [3:0]  WB_Final_Wr;   // [3]=RFWr [2]=CP0Wr [1]=HIWr [0]=LOWr
  logic [4:0]  WB_Dst;
  logic [31:0] WB_Result;
  logic [31:0] WB_HiData;
  logic [31:0] WB_PC;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic [31:0] RF_RsData;
  logic [31:0] RF_RtData;
  logic [31:0] RF_Hi;
  logic [31:0] RF_Lo;
  logic        CP0_WrReq;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] Retired;

  modport slave (
    input  WB_Final_Wr, WB_Dst, WB_Result, WB_HiData, WB_PC, ID_rs, ID_rt,
    output RF_RsData, RF_RtData, RF_Hi, RF_Lo, CP0_WrReq,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
           Retired
  );

  modport master (
    output WB_Final_Wr, WB_Dst, WB_Result, WB_HiData, WB_PC, ID_rs, ID_rt,
    input  RF_RsData, RF_RtData, RF_Hi, RF_Lo, CP0_WrReq,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
           Retired
  );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : MIPS-style writeback register file: 31 GPRs (GPR0 hard-wired to
//             zero), HI/LO, optional same-cycle write-to-read forwarding,
//             registered CP0 write request, one-cycle commit trace and a
//             free-running count of committed writes.
//  Ports    : clk  - sole clock, rising edge
//             rst  - synchronous, active-high reset
//             bus  - wb_regfile_if.slave (write side, read addresses, outputs)
//  Params   : BYPASS - 1: reads forward the in-flight writeback data
//                      0: reads return stored contents only
//  Revision : 1.0  initial release
// ============================================================================
module wb_regfile #(
  parameter int BYPASS = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  wb_regfile_if.slave       bus
);

  localparam int RF_WR  = 3;
  localparam int CP0_WR = 2;
  localparam int HI_WR  = 1;
  localparam int LO_WR  = 0;

  // Write-enable decode; a GPR write to index 0 is dropped everywhere.
  logic w_rf_wr;
  logic w_gpr_wr;
  logic w_hi_wr;
  logic w_lo_wr;

  assign w_rf_wr  = bus.WB_Final_Wr[RF_WR];
  assign w_gpr_wr = w_rf_wr && (bus.WB_Dst != 5'd0);
  assign w_hi_wr  = bus.WB_Final_Wr[HI_WR];
  assign w_lo_wr  = bus.WB_Final_Wr[LO_WR];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] gpr_q [1:31];
  logic [31:0] gpr_d [1:31];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        cp0_wr_req_q, cp0_wr_req_d;
  logic [31:0] trace_pc_q, trace_pc_d;
  logic [3:0]  trace_wen_q, trace_wen_d;
  logic [4:0]  trace_wnum_q, trace_wnum_d;
  logic [31:0] trace_wdata_q, trace_wdata_d;
  logic [31:0] retired_q, retired_d;

  // Next-state: reset wins over any simultaneous write.
  always_comb begin
    gpr_d         = gpr_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    cp0_wr_req_d  = bus.WB_Final_Wr[CP0_WR];
    trace_pc_d    = bus.WB_PC;
    trace_wen_d   = {4{w_gpr_wr}};
    trace_wnum_d  = bus.WB_Dst;
    trace_wdata_d = bus.WB_Result;
    retired_d     = (|bus.WB_Final_Wr) ? retired_q + 32'd1 : retired_q;

    if (w_gpr_wr) begin
      gpr_d[bus.WB_Dst] = bus.WB_Result;
    end
    if (w_hi_wr) begin
      hi_d = bus.WB_HiData;
    end
    if (w_lo_wr) begin
      lo_d = bus.WB_Result;
    end

    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        gpr_d[i] = 32'd0;
      end
      hi_d          = 32'd0;
      lo_d          = 32'd0;
      cp0_wr_req_d  = 1'b0;
      trace_pc_d    = 32'd0;
      trace_wen_d   = 4'd0;
      trace_wnum_d  = 5'd0;
      trace_wdata_d = 32'd0;
      retired_d     = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    gpr_q         <= gpr_d;
    hi_q          <= hi_d;
    lo_q          <= lo_d;
    cp0_wr_req_q  <= cp0_wr_req_d;
    trace_pc_q    <= trace_pc_d;
    trace_wen_q   <= trace_wen_d;
    trace_wnum_q  <= trace_wnum_d;
    trace_wdata_q <= trace_wdata_d;
    retired_q     <= retired_d;
  end

  // --------------------------------------------------------------------------
  // Combinational reads. Forwarding is deliberately not gated by rst so the
  // decode stage sees the in-flight value even in a reset cycle.
  // --------------------------------------------------------------------------
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi_rd;
  logic [31:0] lo_rd;

  always_comb begin
    rs_data = 32'd0;
    if (bus.ID_rs != 5'd0) begin
      rs_data = gpr_q[bus.ID_rs];
      if ((BYPASS != 0) && w_rf_wr && (bus.WB_Dst == bus.ID_rs)) begin
        rs_data = bus.WB_Result;
      end
    end
  end

  always_comb begin
    rt_data = 32'd0;
    if (bus.ID_rt != 5'd0) begin
      rt_data = gpr_q[bus.ID_rt];
      if ((BYPASS != 0) && w_rf_wr && (bus.WB_Dst == bus.ID_rt)) begin
        rt_data = bus.WB_Result;
      end
    end
  end

  always_comb begin
    hi_rd = hi_q;
    lo_rd = lo_q;
    if (BYPASS != 0) begin
      if (w_hi_wr) begin
        hi_rd = bus.WB_HiData;
      end
      if (w_lo_wr) begin
        lo_rd = bus.WB_Result;
      end
    end
  end

  assign bus.RF_RsData         = rs_data;
  assign bus.RF_RtData         = rt_data;
  assign bus.RF_Hi             = hi_rd;
  assign bus.RF_Lo             = lo_rd;
  assign bus.CP0_WrReq         = cp0_wr_req_q;
  assign bus.debug_wb_pc       = trace_pc_q;
  assign bus.debug_wb_rf_wen   = trace_wen_q;
  assign bus.debug_wb_rf_wnum  = trace_wnum_q;
  assign bus.debug_wb_rf_wdata = trace_wdata_q;
  assign bus.Retired           = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Bench for wb_regfile. Two instances (BYPASS=1 and BYPASS=0)
//             share identical stimulus. The driver computes the expected
//             outputs from a behavioural model and queues them; a monitor
//             pops and compares once per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_regfile_if bus1 ();
  wb_regfile_if bus0 ();

  assign bus0.WB_Final_Wr = bus1.WB_Final_Wr;
  assign bus0.WB_Dst      = bus1.WB_Dst;
  assign bus0.WB_Result   = bus1.WB_Result;
  assign bus0.WB_HiData   = bus1.WB_HiData;
  assign bus0.WB_PC       = bus1.WB_PC;
  assign bus0.ID_rs       = bus1.ID_rs;
  assign bus0.ID_rt       = bus1.ID_rt;

  wb_regfile #(.BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  wb_regfile #(.BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  typedef struct {
    logic [31:0] rs1, rt1, hi1, lo1;   // BYPASS=1 instance reads
    logic [31:0] rs0, rt0, hi0, lo0;   // BYPASS=0 instance reads
    logic        cp0;
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic [31:0] retired;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural architectural state
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo, m_ret, m_pc, m_wdata;
  logic        m_cp0;
  logic [3:0]  m_wen;
  logic [4:0]  m_wnum;

  function automatic logic [31:0] model_rd(input bit byp, input logic [4:0] a,
                                           input logic [3:0] wr, input logic [4:0] dst,
                                           input logic [31:0] res);
    if (a == 5'd0) return 32'd0;
    if (byp && wr[3] && dst == a) return res;
    return m_gpr[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: apply inputs, queue expected outputs, advance model.
  task automatic drive(input bit r, input logic [3:0] wr, input logic [4:0] dst,
                       input logic [31:0] res, input logic [31:0] hid,
                       input logic [31:0] pc, input logic [4:0] rs,
                       input logic [4:0] rt, input bit push);
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus1.WB_Final_Wr = wr;
    bus1.WB_Dst      = dst;
    bus1.WB_Result   = res;
    bus1.WB_HiData   = hid;
    bus1.WB_PC       = pc;
    bus1.ID_rs       = rs;
    bus1.ID_rt       = rt;
    if (push) begin
      e.rs1     = model_rd(1'b1, rs, wr, dst, res);
      e.rt1     = model_rd(1'b1, rt, wr, dst, res);
      e.rs0     = model_rd(1'b0, rs, wr, dst, res);
      e.rt0     = model_rd(1'b0, rt, wr, dst, res);
      e.hi1     = wr[1] ? hid : m_hi;
      e.lo1     = wr[0] ? res : m_lo;
      e.hi0     = m_hi;
      e.lo0     = m_lo;
      e.cp0     = m_cp0;
      e.pc      = m_pc;
      e.wen     = m_wen;
      e.wnum    = m_wnum;
      e.wdata   = m_wdata;
      e.retired = m_ret;
      sb.push_back(e);
    end
    // Effect of the coming rising edge
    if (r) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_hi = 0; m_lo = 0; m_ret = 0; m_cp0 = 0;
      m_pc = 0; m_wen = 0; m_wnum = 0; m_wdata = 0;
    end else begin
      if (wr[3] && dst != 0) m_gpr[dst] = res;
      if (wr[1]) m_hi = hid;
      if (wr[0]) m_lo = res;
      if (wr != 0) m_ret = m_ret + 1;
      m_cp0   = wr[2];
      m_pc    = pc;
      m_wen   = (wr[3] && dst != 0) ? 4'hF : 4'h0;
      m_wnum  = dst;
      m_wdata = res;
    end
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
    drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 32'h0000_0BAD, rs, rt, 1'b1);
  endtask

  // Monitor: every cycle, after inputs settle, compare against queued entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rs_byp1",   bus1.RF_RsData, e.rs1);
        chk("rt_byp1",   bus1.RF_RtData, e.rt1);
        chk("hi_byp1",   bus1.RF_Hi,     e.hi1);
        chk("lo_byp1",   bus1.RF_Lo,     e.lo1);
        chk("rs_byp0",   bus0.RF_RsData, e.rs0);
        chk("rt_byp0",   bus0.RF_RtData, e.rt0);
        chk("hi_byp0",   bus0.RF_Hi,     e.hi0);
        chk("lo_byp0",   bus0.RF_Lo,     e.lo0);
        chk("cp0_req",   {31'd0, bus1.CP0_WrReq}, {31'd0, e.cp0});
        chk("cp0_req0",  {31'd0, bus0.CP0_WrReq}, {31'd0, e.cp0});
        chk("trace_pc",  bus1.debug_wb_pc, e.pc);
        chk("trace_wen", {28'd0, bus1.debug_wb_rf_wen}, {28'd0, e.wen});
        chk("trace_num", {27'd0, bus1.debug_wb_rf_wnum}, {27'd0, e.wnum});
        chk("trace_dat", bus1.debug_wb_rf_wdata, e.wdata);
        chk("retired",   bus1.Retired, e.retired);
        chk("retired0",  bus0.Retired, e.retired);
      end
    end
  end

  initial begin
    logic [3:0]  wr;
    logic [4:0]  dst, rs, rt;
    bit          r;
    rst = 1'b1;
    bus1.WB_Final_Wr = 0; bus1.WB_Dst = 0; bus1.WB_Result = 0;
    bus1.WB_HiData = 0; bus1.WB_PC = 0; bus1.ID_rs = 0; bus1.ID_rt = 0;

    // First reset edge: DUT state is unknown before it, so nothing is queued.
    drive(1'b1, 4'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    drive(1'b1, 4'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd31, 1'b1);

    // GPR write then read back, trace shows the commit
    drive(1'b0, 4'b1000, 5'd5, 32'hDEAD_BEEF, 32'd0, 32'h0000_0100, 5'd5, 5'd0, 1'b1);
    idle(5'd5, 5'd5);
    // Write to GPR0 is discarded but still counts as retired
    drive(1'b0, 4'b1000, 5'd0, 32'h1234_5678, 32'd0, 32'h0000_0104, 5'd0, 5'd0, 1'b1);
    idle(5'd0, 5'd5);
    // Same-cycle forward on both ports
    drive(1'b0, 4'b1000, 5'd7, 32'hA5A5_A5A5, 32'd0, 32'h0000_0108, 5'd7, 5'd7, 1'b1);
    idle(5'd7, 5'd7);
    drive(1'b0, 4'b1000, 5'd7, 32'h5A5A_5A5A, 32'd0, 32'h0000_010C, 5'd7, 5'd7, 1'b1);
    idle(5'd7, 5'd7);
    // HI and LO together: one retirement
    drive(1'b0, 4'b0011, 5'd0, 32'h0000_0002, 32'h0000_0001, 32'h0000_0110, 5'd0, 5'd0, 1'b1);
    idle(5'd0, 5'd0);
    // CP0 request is registered only
    drive(1'b0, 4'b0100, 5'd9, 32'h0000_0099, 32'd0, 32'h0000_0114, 5'd9, 5'd0, 1'b1);
    idle(5'd9, 5'd0);

    // Counter wrap: preload all-ones through an idle cycle, then one write.
    idle(5'd0, 5'd0);
    #3;
    force dut1.retired_q = 32'hFFFF_FFFF;
    force dut0.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut1.retired_q;
    release dut0.retired_q;
    m_ret = 32'hFFFF_FFFF;
    drive(1'b0, 4'b1000, 5'd3, 32'h0000_0055, 32'd0, 32'h0000_0118, 5'd3, 5'd0, 1'b1);
    idle(5'd3, 5'd0);
    // Reset beats a simultaneous write
    drive(1'b1, 4'b1111, 5'd3, 32'h0000_0077, 32'h0000_0066, 32'h0000_011C, 5'd3, 5'd3, 1'b1);
    idle(5'd3, 5'd3);

    // Randomized traffic; read addresses often collide with the destination
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 63) == 0);
      wr  = 4'($urandom);
      dst = 5'($urandom);
      rs  = $urandom_range(0, 1) ? dst : 5'($urandom);
      rt  = $urandom_range(0, 2) == 0 ? dst : 5'($urandom);
      drive(r, wr, dst, $urandom, $urandom, $urandom, rs, rt, 1'b1);
    end
    idle(5'd0, 5'd0);

    repeat (3) @(negedge clk);
    #4;
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
